// File: rtl/viterbi_pkg.sv
// Shared constants, metric type and encoder helper for the
// K=7 rate-1/2 hard-decision Viterbi decoder.
package viterbi_pkg;

    localparam int K          = 7;
    localparam int SW         = K - 1;
    localparam int NUM_STATES = 1 << SW;
    localparam int PM_W       = 8;
    localparam int PM_INIT    = 32;

    localparam logic [K-1:0] G0 = 7'o171;
    localparam logic [K-1:0] G1 = 7'o133;

    typedef logic [PM_W-1:0] pm_t;

    function automatic logic [1:0] exp_pair(input logic u,
                                            input logic [SW-1:0] p);
        logic [K-1:0] r;
        r = {u, p};
        return {^(r & G0), ^(r & G1)};
    endfunction

endpackage

// File: rtl/acs_node.sv
// One add-compare-select cell: two candidate metrics in,
// survivor metric and decision bit out.
module acs_node
    import viterbi_pkg::*;
(
    input  pm_t        pm0,
    input  pm_t        pm1,
    input  logic [1:0] bm0,
    input  logic [1:0] bm1,
    output pm_t        pm_sel,
    output logic       dec
);

    logic [PM_W:0] m0;
    logic [PM_W:0] m1;

    assign m0 = {1'b0, pm0} + {{(PM_W-1){1'b0}}, bm0};
    assign m1 = {1'b0, pm1} + {{(PM_W-1){1'b0}}, bm1};

    // ties resolve to the even predecessor
    assign dec    = m1 < m0;
    assign pm_sel = dec ? m1[PM_W-1:0] : m0[PM_W-1:0];

    always_comb begin
        assert (!(m0[PM_W] || m1[PM_W]));
    end

endmodule

// File: rtl/acs_pm_array.sv
// 64-state ACS array with path-metric storage, normalisation
// and best-state search for the Viterbi traceback.
module acs_pm_array
    import viterbi_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [1:0]            rx_pair,
    output logic                  out_valid,
    output logic [NUM_STATES-1:0] decisions,
    output logic [SW-1:0]         best_state,
    output pm_t                   best_pm,
    output logic                  norm_event
);

    pm_t                   pm     [NUM_STATES];
    pm_t                   pm_n   [NUM_STATES];
    pm_t                   pm_new [NUM_STATES];
    logic [NUM_STATES-1:0] msb;
    logic [NUM_STATES-1:0] dec;
    logic                  norm;

    pm_t           tpm [2*NUM_STATES-1];
    logic [SW-1:0] tix [2*NUM_STATES-1];

    function automatic logic [1:0] hamming(input logic [1:0] a,
                                           input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {x[1] & x[0], x[1] ^ x[0]};
    endfunction

    assign norm = &msb;

    for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
        localparam logic [SW-1:0] NS = SW'(s);
        localparam logic [SW-1:0] P0 = {NS[SW-2:0], 1'b0};
        localparam logic [SW-1:0] P1 = {NS[SW-2:0], 1'b1};
        localparam logic [1:0]    E0 = exp_pair(NS[SW-1], P0);
        localparam logic [1:0]    E1 = exp_pair(NS[SW-1], P1);

        assign msb[s]  = pm[s][PM_W-1];
        assign pm_n[s] = norm ? {1'b0, pm[s][PM_W-2:0]} : pm[s];

        acs_node u_acs (
            .pm0    (pm_n[P0]),
            .pm1    (pm_n[P1]),
            .bm0    (hamming(rx_pair, E0)),
            .bm1    (hamming(rx_pair, E1)),
            .pm_sel (pm_new[s]),
            .dec    (dec[s])
        );
    end

    // heap-ordered min tree; left subtree holds lower indices
    always_comb begin
        for (int i = 0; i < NUM_STATES; i++) begin
            tpm[NUM_STATES-1+i] = pm_new[i];
            tix[NUM_STATES-1+i] = SW'(i);
        end
        for (int n = NUM_STATES - 2; n >= 0; n--) begin
            if (tpm[2*n+2] < tpm[2*n+1]) begin
                tpm[n] = tpm[2*n+2];
                tix[n] = tix[2*n+2];
            end else begin
                tpm[n] = tpm[2*n+1];
                tix[n] = tix[2*n+1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STATES; i++)
                pm[i] <= (i == 0) ? '0 : pm_t'(PM_INIT);
            out_valid  <= 1'b0;
            decisions  <= '0;
            best_state <= '0;
            best_pm    <= '0;
            norm_event <= 1'b0;
        end else if (start) begin
            for (int i = 0; i < NUM_STATES; i++)
                pm[i] <= (i == 0) ? '0 : pm_t'(PM_INIT);
            out_valid  <= 1'b0;
            decisions  <= '0;
            best_state <= '0;
            best_pm    <= '0;
            norm_event <= 1'b0;
        end else if (in_valid) begin
            for (int i = 0; i < NUM_STATES; i++)
                pm[i] <= pm_new[i];
            out_valid  <= 1'b1;
            decisions  <= dec;
            best_state <= tix[0];
            best_pm    <= tpm[0];
            norm_event <= norm;
        end else begin
            out_valid  <= 1'b0;
            norm_event <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acs_pm_array.sv
// Scoreboard bench for acs_pm_array: directed hand vectors plus
// an independent forward-trellis model for streamed symbols.
module tb_acs_pm_array;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  rx_pair = 2'b00;
    logic        out_valid;
    logic [63:0] decisions;
    logic [5:0]  best_state;
    logic [7:0]  best_pm;
    logic        norm_event;

    acs_pm_array dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .rx_pair    (rx_pair),
        .out_valid  (out_valid),
        .decisions  (decisions),
        .best_state (best_state),
        .best_pm    (best_pm),
        .norm_event (norm_event)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] dec;
        logic [63:0] mask;
        logic [5:0]  bs;
        logic [7:0]  bpm;
        logic        norm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   mpm [64];
    int   model_norms = 0;
    int   carry_bad = 0;
    logic [6:0] g0 = 7'b1111001;
    logic [6:0] g1 = 7'b1011011;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic par7(input logic [6:0] v);
        logic p = 1'b0;
        for (int i = 0; i < 7; i++) p = p ^ v[i];
        return p;
    endfunction

    task automatic model_init();
        for (int i = 0; i < 64; i++) mpm[i] = (i == 0) ? 0 : 32;
    endtask

    // forward trellis walk: each predecessor fans out to its two successors
    task automatic model_step(input logic [1:0] rx, output exp_t e);
        int    npm [64];
        bit    all_hi = 1'b1;
        logic [63:0] d = '0;
        logic [6:0]  r;
        logic [1:0]  x;
        int    ns, c, bi;
        for (int i = 0; i < 64; i++) if (mpm[i] < 128) all_hi = 1'b0;
        if (all_hi) begin
            model_norms++;
            for (int i = 0; i < 64; i++) mpm[i] -= 128;
        end
        for (int i = 0; i < 64; i++) npm[i] = 100000;
        for (int p = 0; p < 64; p++) begin
            for (int u = 0; u < 2; u++) begin
                r  = {u[0], p[5:0]};
                x  = rx ^ {par7(r & g0), par7(r & g1)};
                ns = u * 32 + p / 2;
                c  = mpm[p] + int'(x[0]) + int'(x[1]);
                if (c > 255) carry_bad++;
                if (c < npm[ns]) begin
                    npm[ns] = c;
                    d[ns]   = p[0];
                end
            end
        end
        bi = 0;
        for (int i = 1; i < 64; i++) if (npm[i] < npm[bi]) bi = i;
        for (int i = 0; i < 64; i++) mpm[i] = npm[i];
        e.dec  = d;
        e.mask = '1;
        e.bs   = bi[5:0];
        e.bpm  = npm[bi][7:0];
        e.norm = all_hi;
    endtask

    task automatic drive(input logic [1:0] rx, input exp_t e);
        sb.push_back(e);
        in_valid = 1'b1;
        rx_pair  = rx;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] rx);
        exp_t e;
        model_step(rx, e);
        drive(rx, e);
    endtask

    task automatic issue_dir(input logic [1:0] rx, input int bit_idx,
                             input logic [5:0] bs, input logic [7:0] bpm);
        exp_t e;
        model_step(rx, e);
        e.dec  = '0;
        e.mask = '0;
        e.mask[bit_idx] = 1'b1;
        e.bs   = bs;
        e.bpm  = bpm;
        e.norm = 1'b0;
        drive(rx, e);
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        model_init();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    chk("decisions", decisions & e.mask, e.dec & e.mask);
                    chk("best_state", 64'(best_state), 64'(e.bs));
                    chk("best_pm", 64'(best_pm), 64'(e.bpm));
                    chk("norm_event", 64'(norm_event), 64'(e.norm));
                end
            end
        end
    end

    initial begin : stim
        exp_t e;
        logic [5:0] enc;
        logic       u;
        logic [6:0] r;
        int         wait_cyc;

        @(posedge clk);
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_decisions", decisions, 64'd0);
        chk("rst_best_pm", 64'(best_pm), 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        pulse_start();
        for (int i = 0; i < 10; i++) issue_dir(2'b00, 0, 6'd0, 8'd0);

        pulse_start();
        issue_dir(2'b11, 32, 6'd32, 8'd0);
        issue_dir(2'b00, 16, 6'd16, 8'd1);
        for (int i = 0; i < 4; i++) issue(2'($urandom_range(0, 3)));

        in_valid = 1'b1;
        start    = 1'b1;
        rx_pair  = 2'b00;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        model_init();
        @(posedge clk);
        #1;
        issue_dir(2'b11, 32, 6'd32, 8'd0);

        pulse_start();
        enc = '0;
        for (int i = 0; i < 200; i++) begin
            u = 1'($urandom);
            r = {u, enc};
            enc = {u, enc[5:1]};
            model_step({par7(r & g0), par7(r & g1)}, e);
            e.bpm = 8'd0;
            drive({par7(r & g0), par7(r & g1)}, e);
        end

        pulse_start();
        for (int i = 0; i < 5000; i++) issue(2'($urandom_range(0, 3)));
        chk("norm_seen", 64'(model_norms > 0), 64'd1);
        chk("no_carry", 64'(carry_bad), 64'd0);

        pulse_start();
        for (int i = 0; i < 30; i++) issue(2'($urandom_range(0, 3)));
        #1;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_decisions", decisions, 64'd0);
        chk("async_best_state", 64'(best_state), 64'd0);
        chk("async_best_pm", 64'(best_pm), 64'd0);
        chk("async_norm", 64'(norm_event), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        model_init();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        issue_dir(2'b11, 32, 6'd32, 8'd0);
        for (int i = 0; i < 40; i++) issue(2'($urandom_range(0, 3)));
        in_valid = 1'b0;

        wait_cyc = 0;
        while (sb.size() != 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        chk("drain", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
